// File: rtl/top.sv
// ---------------------------------------------------------------------------
// AES-128 encryption core behind an Avalon-MM slave interface.
//
// The host loads plaintext and key, then writes CTRL bit0 to start. The core
// runs one AES round per clock and expands the round keys on the fly. The
// result is in CT0-CT3 ten clocks after the start edge. 128-bit values use
// FIPS-197 byte order: bits [127:120] hold byte 0.
//
// Ports
//   iClk           system clock, rising-edge active
//   iReset_n       asynchronous active-low reset
//   iChipSelect_n  chip select, active-low
//   iWrite_n       write strobe, active-low
//   iRead_n        read strobe, active-low
//   iAddress       word address
//   iWriteData     write data
//   iByteEnable    per-byte write enables
//   oReadData      read data; combinational, zero wait states
//
// Register map (word addresses)
//   0x00-0x03 PT0-PT3    plaintext [31:0]..[127:96], R/W
//   0x04-0x07 KEY0-KEY3  key       [31:0]..[127:96], R/W
//   0x0C      CTRL/STAT  rd: bit0 busy, bit1 done; wr: bit0 = start
//   0x0D-0x10 CT0-CT3    ciphertext [31:0]..[127:96], RO
//   anything else reads 0 and ignores writes
// ---------------------------------------------------------------------------

// Combinational AES S-box lookup.
module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);
  // Byte k of the table sits at bits [2047-8k -: 8].
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // 2040 - 8*in equals {~in, 3'b000}, so the index needs no arithmetic.
  logic [10:0] bit_idx;
  assign bit_idx = {~in_i, 3'b000};
  assign out_o   = SBOX_TBL[bit_idx +: 8];
endmodule

module top #(
  parameter int KEY_SIZE = 128
) (
  input  logic        iClk,
  input  logic        iReset_n,
  input  logic        iChipSelect_n,
  input  logic        iWrite_n,
  input  logic        iRead_n,
  input  logic [5:0]  iAddress,
  input  logic [31:0] iWriteData,
  input  logic [3:0]  iByteEnable,
  output logic [31:0] oReadData
);

  // Only AES-128 exists. Any other KEY_SIZE builds the same AES-128 core.
  if (KEY_SIZE != 128) begin : g_key_size_fallback_aes128
  end

  localparam logic [5:0] ADDR_CTRL = 6'h0C;
  localparam logic [3:0] LAST_RND  = 4'd10;

  typedef enum logic {IDLE, RUN} fsm_e;

  // ---------------- bus decode ----------------
  logic        wr_en, rd_en, start_req;
  logic [31:0] wmask;

  assign wr_en     = !iChipSelect_n && !iWrite_n;
  assign rd_en     = !iChipSelect_n && !iRead_n;
  assign start_req = wr_en && (iAddress == ADDR_CTRL) && iByteEnable[0] && iWriteData[0];
  assign wmask     = {{8{iByteEnable[3]}}, {8{iByteEnable[2]}},
                      {8{iByteEnable[1]}}, {8{iByteEnable[0]}}};

  // Word n of each register holds bits [32n+31:32n].
  logic [3:0][31:0] pt_q, key_q, ct_q;
  logic [127:0]     state_q, rkey_q;
  logic [3:0]       round_q;
  logic             done_q;
  fsm_e             fsm_q, fsm_d;

  logic busy, load_en, step_en, last_round;

  // ---------------- FSM: state register ----------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of all others, independent of process ordering.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) fsm_q <= IDLE;
    else           fsm_q <= fsm_d;
  end

  // ---------------- FSM: next state ----------------
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (start_req) fsm_d = RUN;
      RUN:     if (round_q == LAST_RND) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // A start while RUN is ignored because load_en exists only in IDLE.
  always_comb begin
    busy       = 1'b0;
    load_en    = 1'b0;
    step_en    = 1'b0;
    last_round = 1'b0;
    case (fsm_q)
      IDLE: load_en = start_req;
      RUN: begin
        busy       = 1'b1;
        step_en    = 1'b1;
        last_round = (round_q == LAST_RND);
      end
      default: ;
    endcase
  end

  // ---------------- PT / KEY registers ----------------
  // Frozen while busy so the running encryption and its key cannot change.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      pt_q  <= '0;
      key_q <= '0;
    end else if (wr_en && !busy) begin
      if (iAddress[5:2] == 4'h0)
        pt_q[iAddress[1:0]]  <= (pt_q[iAddress[1:0]] & ~wmask) | (iWriteData & wmask);
      else if (iAddress[5:2] == 4'h1)
        key_q[iAddress[1:0]] <= (key_q[iAddress[1:0]] & ~wmask) | (iWriteData & wmask);
    end
  end

  // ---------------- round datapath ----------------
  logic [127:0] sb, sr, mc, rk_next, round_out;
  logic [31:0]  rot_w, sub_rot, t_w;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // 16 state S-boxes; byte k of the state is bits [127-8k -: 8].
  for (genvar k = 0; k < 16; k++) begin : g_state_sbox
    aes_sbox u_sbox (.in_i(state_q[127-8*k -: 8]), .out_o(sb[127-8*k -: 8]));
  end

  // ShiftRows: row r of column c takes the byte from column (c+r) mod 4.
  always_comb begin
    sr = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[127-8*(r+4*c) -: 8] = sb[127-8*(r+4*((c+r)%4)) -: 8];
  end

  always_comb begin
    mc = '0;
    for (int c = 0; c < 4; c++)
      mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
  end

  // On-the-fly key schedule: 4 S-boxes on RotWord(w3).
  assign rot_w = {rkey_q[23:0], rkey_q[31:24]};
  for (genvar k = 0; k < 4; k++) begin : g_key_sbox
    aes_sbox u_sbox (.in_i(rot_w[31-8*k -: 8]), .out_o(sub_rot[31-8*k -: 8]));
  end
  assign t_w = sub_rot ^ {rcon(round_q), 24'h0};

  always_comb begin
    rk_next[127:96] = rkey_q[127:96] ^ t_w;
    rk_next[95:64]  = rkey_q[95:64]  ^ rk_next[127:96];
    rk_next[63:32]  = rkey_q[63:32]  ^ rk_next[95:64];
    rk_next[31:0]   = rkey_q[31:0]   ^ rk_next[63:32];
  end

  // The final round skips MixColumns.
  assign round_out = (last_round ? sr : mc) ^ rk_next;

  // ---------------- core state ----------------
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q <= '0;
      rkey_q  <= '0;
      round_q <= '0;
      ct_q    <= '0;
      done_q  <= 1'b0;
    end else if (load_en) begin
      state_q <= pt_q ^ key_q;
      rkey_q  <= key_q;
      round_q <= 4'd1;
      done_q  <= 1'b0;
    end else if (step_en) begin
      state_q <= round_out;
      rkey_q  <= rk_next;
      if (last_round) begin
        // CT changes only here, so intermediate rounds never show on the bus.
        ct_q    <= round_out;
        done_q  <= 1'b1;
        round_q <= '0;
      end else begin
        round_q <= round_q + 4'd1;
      end
    end
  end

  // ---------------- read mux ----------------
  always_comb begin
    oReadData = '0;
    if (rd_en) begin
      case (iAddress)
        6'h00, 6'h01, 6'h02, 6'h03: oReadData = pt_q[iAddress[1:0]];
        6'h04, 6'h05, 6'h06, 6'h07: oReadData = key_q[iAddress[1:0]];
        ADDR_CTRL:                  oReadData = {30'b0, done_q, busy};
        6'h0D:                      oReadData = ct_q[0];
        6'h0E:                      oReadData = ct_q[1];
        6'h0F:                      oReadData = ct_q[2];
        6'h10:                      oReadData = ct_q[3];
        default:                    oReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_top.sv
// ---------------------------------------------------------------------------
// Self-checking bench for the AES-128 Avalon-MM core (module top).
// Directed vectors: reset map, byte enables, FIPS-197 C.1 and Appendix B,
// start/KEY write while busy, and reset in the middle of an encryption.
// ---------------------------------------------------------------------------
module tb_top;

  logic        iClk = 1'b0;
  logic        iReset_n;
  logic        iChipSelect_n;
  logic        iWrite_n;
  logic        iRead_n;
  logic [5:0]  iAddress;
  logic [31:0] iWriteData;
  logic [3:0]  iByteEnable;
  logic [31:0] oReadData;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  top #(.KEY_SIZE(128)) dut (
    .iClk          (iClk),
    .iReset_n      (iReset_n),
    .iChipSelect_n (iChipSelect_n),
    .iWrite_n      (iWrite_n),
    .iRead_n       (iRead_n),
    .iAddress      (iAddress),
    .iWriteData    (iWriteData),
    .iByteEnable   (iByteEnable),
    .oReadData     (oReadData)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    iChipSelect_n = 1'b1;
    iWrite_n      = 1'b1;
    iRead_n       = 1'b1;
  endtask

  // Present a write; it is taken on the next rising edge.
  task automatic drive_wr(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] be);
    iAddress      = addr;
    iWriteData    = data;
    iByteEnable   = be;
    iChipSelect_n = 1'b0;
    iWrite_n      = 1'b0;
  endtask

  task automatic bus_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] be);
    @(negedge iClk);
    drive_wr(addr, data, be);
    @(posedge iClk);
    #1 bus_idle();
  endtask

  // Zero-wait-state read: no clock edge consumed.
  task automatic bus_read(input logic [5:0] addr, output logic [31:0] data);
    iAddress      = addr;
    iChipSelect_n = 1'b0;
    iRead_n       = 1'b0;
    #1 data = oReadData;
    bus_idle();
  endtask

  task automatic load_block(input logic [127:0] pt, input logic [127:0] key);
    for (int w = 0; w < 4; w++) begin
      bus_write(6'(w),     pt[32*w +: 32],  4'hF);
      bus_write(6'(w + 4), key[32*w +: 32], 4'hF);
    end
  endtask

  task automatic check_ct(input string tag, input logic [127:0] exp);
    logic [31:0] rd;
    for (int w = 0; w < 4; w++) begin
      bus_read(6'h0D + 6'(w), rd);
      check($sformatf("%s CT%0d", tag, w), rd, exp[32*w +: 32]);
    end
  endtask

  // Start, then check status after every edge: busy for 9 edges, done on
  // the 10th. With inject set, a KEY0 write and a second start land mid-run.
  task automatic run_and_check(input string tag, input bit inject);
    logic [31:0] rd;
    bus_write(6'h0C, 32'h1, 4'h1);
    for (int i = 1; i <= 10; i++) begin
      if (inject && i == 3) drive_wr(6'h04, 32'hFFFF_FFFF, 4'hF);
      if (inject && i == 4) drive_wr(6'h0C, 32'h1, 4'hF);
      @(posedge iClk);
      #1 bus_idle();
      #1 bus_read(6'h0C, rd);
      check($sformatf("%s status edge %0d", tag, i), rd, (i < 10) ? 32'h1 : 32'h2);
    end
  endtask

  initial begin
    logic [31:0] rd;
    bus_idle();
    iAddress    = '0;
    iWriteData  = '0;
    iByteEnable = '0;
    iReset_n    = 1'b0;
    repeat (3) @(posedge iClk);
    @(negedge iClk) iReset_n = 1'b1;

    // Reset map: every address reads 0.
    for (int a = 0; a < 64; a++) begin
      bus_read(6'(a), rd);
      check($sformatf("reset addr %02h", a), rd, 32'h0);
    end

    // Byte enables on PT0 starting from 0.
    bus_write(6'h00, 32'hAABB_CCDD, 4'b0101);
    bus_read(6'h00, rd);
    check("byte enable PT0", rd, 32'h00BB_00DD);

    // Reserved and read-only space ignore writes.
    bus_write(6'h08, 32'h1234_5678, 4'hF);
    bus_read(6'h08, rd);
    check("reserved 08", rd, 32'h0);
    bus_write(6'h0D, 32'h1234_5678, 4'hF);
    bus_read(6'h0D, rd);
    check("CT0 read-only", rd, 32'h0);

    // FIPS-197 C.1.
    load_block(C1_PT, C1_KEY);
    bus_read(6'h03, rd);
    check("PT3 readback", rd, 32'h0011_2233);
    bus_read(6'h04, rd);
    check("KEY0 readback", rd, 32'h0c0d_0e0f);
    run_and_check("C1", 1'b0);
    check_ct("C1", C1_CT);

    // FIPS-197 Appendix B; the previous done must clear on start.
    load_block(B_PT, B_KEY);
    bus_read(6'h0C, rd);
    check("B status before start", rd, 32'h2);
    run_and_check("B", 1'b0);
    check_ct("B", B_CT);

    // Start and KEY0 write while busy are ignored.
    load_block(C1_PT, C1_KEY);
    run_and_check("busy inject", 1'b1);
    check_ct("busy inject", C1_CT);
    bus_read(6'h04, rd);
    check("KEY0 unchanged", rd, 32'h0c0d_0e0f);

    // Reset five edges after start aborts the run.
    bus_write(6'h0C, 32'h1, 4'h1);
    repeat (5) @(posedge iClk);
    #2 iReset_n = 1'b0;
    #1 bus_read(6'h0C, rd);
    check("mid reset status", rd, 32'h0);
    @(negedge iClk) iReset_n = 1'b1;
    repeat (12) @(posedge iClk);
    #1 bus_read(6'h0C, rd);
    check("after reset status", rd, 32'h0);
    check_ct("after reset", 128'h0);
    bus_read(6'h07, rd);
    check("after reset KEY3", rd, 32'h0);

    // A fresh C.1 run still works.
    load_block(C1_PT, C1_KEY);
    run_and_check("C1 again", 1'b0);
    check_ct("C1 again", C1_CT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameter KEY_SIZE, default 128, AES key width; only 128 is supported, and any other value SHALL still synthesize as AES-128.
REQ-002 iClk  input  1  single system clock; all state changes on its rising edge.
REQ-003 iReset_n  input  1  reset, asynchronous and active-low.
REQ-004 iChipSelect_n  input  1  Avalon-MM chip select, active-low.
REQ-005 iWrite_n  input  1  write strobe, active-low; a write occurs on any edge with iChipSelect_n=0 and iWrite_n=0.
REQ-006 iRead_n  input  1  read strobe, active-low.
REQ-007 iAddress  input  6  word address of the register.
REQ-008 iWriteData  input  32  write data.
REQ-009 iByteEnable  input  4  per-byte write enables; bit n enables bits [8n+7:8n].
REQ-010 oReadData  output  32  read data.

Function
REQ-011 The register map SHALL be as follows:
- 0x00-0x03: PT0-PT3, plaintext bits [31:0] through [127:96], read/write.
- 0x04-0x07: KEY0-KEY3, key bits [31:0] through [127:96], read/write.
- 0x08-0x0B: reserved; writes ignored, reads 0.
- 0x0C: CTRL/STATUS.
- 0x0D-0x10: CT0-CT3, ciphertext bits [31:0] through [127:96], read-only.
- All other addresses: reads 0, writes ignored.
REQ-012 The 128-bit values SHALL use FIPS-197 byte order: bits [127:120] are byte 0 of the block or key.
REQ-013 oReadData SHALL be combinational from iAddress whenever iChipSelect_n=0 and iRead_n=0 (zero wait states), and SHALL be 0 otherwise.
REQ-014 CTRL/STATUS read value: bit0=busy, bit1=done, bits[31:2]=0.
REQ-015 CTRL/STATUS write: bit0=1 with iByteEnable[0]=1 is a start request; all other bits are ignored.
REQ-016 A write to a PT or KEY register SHALL update only the enabled bytes.
REQ-017 While busy=1, writes to PT or KEY are ignored.
REQ-018 Core FSM states SHALL be IDLE and RUN.
REQ-019 In IDLE, a start request SHALL, on the same edge:
- latch state = PT xor KEY;
- latch round key = KEY;
- set round counter = 1;
- set busy=1 and done=0;
- enter RUN.
REQ-020 In RUN, each edge SHALL perform one AES round: SubBytes, ShiftRows, MixColumns, then AddRoundKey with the next on-the-fly expanded round key (Rcon 01,02,04,...,36). Round 10 SHALL omit MixColumns.
REQ-021 On the edge executing round 10, the core SHALL:
- load CT0-CT3 with the result;
- set done=1 and busy=0;
- return to IDLE.
Latency is 10 clock edges after the start-capture edge.
REQ-022 A start request while busy=1 SHALL be ignored.
REQ-023 done SHALL remain 1 until the next accepted start, which clears it.
REQ-024 Reading any register SHALL have no side effects.
REQ-025 CT registers SHALL hold the last result until the next completion; no intermediate values are visible.
REQ-026 S-boxes SHALL be combinational: 16 for the state and 4 for key expansion.

Reset
REQ-027 Asserting iReset_n=0 SHALL asynchronously clear the following, and the core SHALL enter IDLE:
- PT, KEY, CT, internal state, round key and round counter;
- busy and done.
REQ-028 Reset asserted mid-encryption SHALL abort the operation, leaving busy=0, done=0 and CT=0.
REQ-029 After reset, all register reads SHALL return 0.

Verification
REQ-030 FIPS-197 C.1 vector: PT=00112233445566778899aabbccddeeff, KEY=000102030405060708090a0b0c0d0e0f, write 1 to 0x0C, poll until status bit1=1 -> {CT3,CT2,CT1,CT0}=69c4e0d86a7b0430d8cdb78070b4c55a, and done is set exactly 10 cycles after the start edge.
REQ-031 FIPS-197 Appendix B vector: KEY=2b7e151628aed2a6abf7158809cf4f3c, PT=3243f6a8885a308d313198a2e0370734 -> CT=3925841d02dc09fbdc118597196a0b32; the preceding done clears on start, and busy reads 1 during the run.
REQ-032 Reset values: after reset, read every address 0x00-0x3F -> all read 0, and status=0.
REQ-033 Byte enables: write 0xAABBCCDD to PT0 with iByteEnable=0101, after PT0=0 -> PT0 reads 0x00BB00DD.
REQ-034 Start while busy: issue a second start and a KEY0 write during RUN -> the result is unchanged from REQ-030, done arrives on schedule, and KEY0 is unchanged.
REQ-035 Reset mid-operation: assert iReset_n=0 five cycles after start -> status=0 and CT=0; a fresh REQ-030 run afterwards still passes.
